// File: rtl/store_pkg.sv
// Shared types and helpers for the store alignment path.
// Beat = word address, byte enables, lane-rotated write data.
package store_pkg;

  localparam logic [2:0] ST_WORD = 3'b000;
  localparam logic [2:0] ST_BYTE = 3'b001;
  localparam logic [2:0] ST_HALF = 3'b010;

  typedef struct packed {
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } st_beat_t;

  // Rotate left by whole bytes so byte 0 of the register lands on lane off.
  function automatic logic [31:0] rotl_bytes(input logic [31:0] data,
                                             input logic [1:0]  off);
    logic [31:0] r;
    case (off)
      2'd0:    r = data;
      2'd1:    r = {data[23:0], data[31:24]};
      2'd2:    r = {data[15:0], data[31:16]};
      default: r = {data[7:0],  data[31:8]};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/store_beat_fifo.sv
// Synchronous beat FIFO: up to two pushes and one pop per cycle.
// Head reads zero while empty; storage itself is never reset.
module store_beat_fifo
  import store_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             i_push_cnt,
  input  st_beat_t               i_beat0,
  input  st_beat_t               i_beat1,
  input  logic                   i_pop,
  output st_beat_t               o_head,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_free
);

  localparam int AW = $clog2(DEPTH);

  st_beat_t      r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic          w_pop;
  logic [AW-1:0] w_wr_nxt;

  assign w_pop    = i_pop && (r_count != '0);
  assign w_wr_nxt = r_wr_ptr + AW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(i_push_cnt);
      r_rd_ptr <= r_rd_ptr + AW'(w_pop);
      r_count  <= r_count + (AW+1)'(i_push_cnt) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (i_push_cnt != 2'd0) r_mem[r_wr_ptr] <= i_beat0;
      if (i_push_cnt == 2'd2) r_mem[w_wr_nxt] <= i_beat1;
    end
  end

  assign o_empty = (r_count == '0);
  assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];
  assign o_free  = (AW+1)'(DEPTH) - r_count;

endmodule

// File: rtl/store_data_align.sv
// Turns SB/SH/SW requests into word-aligned memory beats via a small FIFO.
// STORE_MISALIGN_SPLIT_EN: split misaligned stores instead of reporting them.
module store_data_align
  import store_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  StFunct,
  input  logic [31:0] Addr,
  input  logic [31:0] Din,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  output logic        misalign_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);

  logic [1:0]  w_off;
  logic [29:0] w_word;
  logic [31:0] w_rot;
  logic [3:0]  w_be0;
  logic [3:0]  w_be1;
  logic [3:0]  w_sw_mask;
  logic        w_accept;
  logic [1:0]  w_push_cnt;
  st_beat_t    w_beat0;
  st_beat_t    w_beat1;
  st_beat_t    w_head;
  logic        w_empty;
  logic [AW:0] w_free;
`ifdef STORE_MISALIGN_SPLIT_EN
  logic        w_two;
`else
  logic        w_mis;
  logic        r_err;
`endif

  assign w_off     = Addr[1:0];
  assign w_word    = Addr[31:2];
  assign w_rot     = rotl_bytes(Din, w_off);
  assign w_sw_mask = 4'b1111 << w_off;

  // Two free slots are always demanded so a split store never needs a stall.
  assign req_ready = (w_free >= (AW+1)'(2));
  assign w_accept  = req_valid && req_ready;

  always_comb begin
    w_be0 = 4'b0000;
    w_be1 = 4'b0000;
`ifdef STORE_MISALIGN_SPLIT_EN
    w_two = 1'b0;
`else
    w_mis = 1'b0;
`endif
    case (StFunct)
      ST_BYTE: w_be0 = 4'b0001 << w_off;
      ST_HALF: begin
        case (w_off)
          2'd0: w_be0 = 4'b0011;
          2'd2: w_be0 = 4'b1100;
`ifdef STORE_MISALIGN_SPLIT_EN
          2'd1: w_be0 = 4'b0110;
          default: begin
            w_be0 = 4'b1000;
            w_be1 = 4'b0001;
            w_two = 1'b1;
          end
`else
          default: w_mis = 1'b1;
`endif
        endcase
      end
      default: begin
`ifdef STORE_MISALIGN_SPLIT_EN
        w_be0 = w_sw_mask;
        w_be1 = ~w_sw_mask;
        w_two = (w_off != 2'd0);
`else
        w_be0 = w_sw_mask;
        w_mis = (w_off != 2'd0);
`endif
      end
    endcase
  end

`ifdef STORE_MISALIGN_SPLIT_EN
  assign w_push_cnt   = !w_accept ? 2'd0 : (w_two ? 2'd2 : 2'd1);
  assign misalign_err = 1'b0;
`else
  assign w_push_cnt   = (w_accept && !w_mis) ? 2'd1 : 2'd0;
  assign misalign_err = r_err;

  always_ff @(posedge clk) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= w_accept && w_mis;
  end
`endif

  // Second beat of a split lands in the next word; the address wraps naturally.
  assign w_beat0 = '{addr: w_word,         be: w_be0, wdata: w_rot};
  assign w_beat1 = '{addr: w_word + 30'd1, be: w_be1, wdata: w_rot};

  store_beat_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push_cnt (w_push_cnt),
    .i_beat0    (w_beat0),
    .i_beat1    (w_beat1),
    .i_pop      (mem_ready),
    .o_head     (w_head),
    .o_empty    (w_empty),
    .o_free     (w_free)
  );

  assign busy      = !w_empty;
  assign mem_valid = !w_empty;
  assign mem_addr  = {w_head.addr, 2'b00};
  assign mem_be    = w_head.be;
  assign mem_wdata = w_head.wdata;

endmodule

// File: tb/tb_store_data_align.sv
// Self-checking bench for store_data_align: directed cases plus random traffic
// compared against a byte-level reference model of memory beats.
module tb_store_data_align;

  localparam int DEPTH = 4;
`ifdef STORE_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  StFunct;
  logic [31:0] Addr;
  logic [31:0] Din;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        misalign_err;
  logic        busy;

  store_data_align #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .StFunct      (StFunct),
    .Addr         (Addr),
    .Din          (Din),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .misalign_err (misalign_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } beat_t;

  beat_t       q[$];
  logic [31:0] pop_log[$];
  bit          exp_err;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: enumerate the bytes a store writes and group them by word.
  function automatic bit model_req(input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] d);
    int          sz;
    int          src;
    int          wi;
    logic [31:0] wd;
    logic [31:0] ba;
    logic [3:0]  be [2];
    logic [29:0] w0;
    logic [29:0] wa;
    beat_t       b;
    sz = (f == 3'b001) ? 1 : (f == 3'b010) ? 2 : 4;
    if ((int'(a[1:0]) % sz) != 0 && !SPLIT) return 1'b1;
    for (int l = 0; l < 4; l++) begin
      src = (l - int'(a[1:0]) + 4) % 4;
      wd[8*l +: 8] = d[8*src +: 8];
    end
    be[0] = 4'b0000;
    be[1] = 4'b0000;
    w0 = a[31:2];
    for (int j = 0; j < sz; j++) begin
      ba = a + 32'(j);
      wi = (ba[31:2] != w0) ? 1 : 0;
      be[wi][ba[1:0]] = 1'b1;
    end
    for (int k = 0; k < 2; k++) begin
      if (be[k] != 4'b0000) begin
        wa     = w0 + 30'(k);
        b.addr = {wa, 2'b00};
        b.be   = be[k];
        b.data = wd;
        q.push_back(b);
      end
    end
    return 1'b0;
  endfunction

  task automatic check_outputs(input string tag);
    logic [127:0] ex;
    ex = '0;
    if (q.size() != 0) ex = {59'd0, 1'b1, q[0].addr, q[0].be, q[0].data};
    chk({tag, ":head"},  {59'd0, mem_valid, mem_addr, mem_be, mem_wdata}, ex);
    chk({tag, ":ready"}, req_ready,    q.size() <= DEPTH - 2);
    chk({tag, ":busy"},  busy,         q.size() != 0);
    chk({tag, ":err"},   misalign_err, exp_err);
  endtask

  task automatic step(input bit v, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] d, input bit rdy, output bit acc);
    @(negedge clk);
    req_valid = v;
    StFunct   = f;
    Addr      = a;
    Din       = d;
    mem_ready = rdy;
    #1;
    if (rdy && mem_valid) pop_log.push_back(mem_addr);
    @(posedge clk);
    acc = v && ((DEPTH - q.size()) >= 2);
    if (rdy && q.size() != 0) void'(q.pop_front());
    exp_err = acc ? model_req(f, a, d) : 1'b0;
    #1;
    check_outputs("step");
  endtask

  task automatic send(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                      input bit rdy);
    bit acc;
    acc = 1'b0;
    for (int n = 0; n < 20 && !acc; n++) step(1'b1, f, a, d, rdy, acc);
    chk("send_accept", acc, 1'b1);
  endtask

  task automatic idle(input bit rdy);
    bit acc;
    step(1'b0, 3'b000, 32'h0, 32'h0, rdy, acc);
  endtask

  task automatic drain();
    for (int n = 0; n < 12 && q.size() != 0; n++) idle(1'b1);
    chk("drain_empty", busy, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 1'b0;
    @(posedge clk);
    q.delete();
    exp_err = 1'b0;
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit          acc;
    logic [2:0]  funcs [5];
    logic [31:0] a;
    funcs = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b111};
    rst = 1'b1; req_valid = 1'b0; StFunct = 3'b000; Addr = '0; Din = '0; mem_ready = 1'b0;
    exp_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset_init");
    @(negedge clk);
    rst = 1'b0;

    // Aligned byte and half.
    send(3'b001, 32'h0000_1003, 32'h0000_00AB, 1'b0);
    chk("sb_beat", {mem_addr, mem_be, mem_wdata}, {32'h1000, 4'b1000, 32'hAB00_0000});
    drain();
    send(3'b010, 32'h0000_2002, 32'h0000_BEEF, 1'b0);
    chk("sh_beat", {mem_addr, mem_be, mem_wdata}, {32'h2000, 4'b1100, 32'hBEEF_0000});
    drain();

    // Word with one-cycle latency, then held under backpressure.
    chk("sw_pre_valid", mem_valid, 1'b0);
    send(3'b000, 32'h0000_3000, 32'h1234_5678, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("sw_hold", {mem_valid, mem_addr, mem_be, mem_wdata},
          {1'b1, 32'h3000, 4'b1111, 32'h1234_5678});
      idle(1'b0);
    end
    drain();

    // Backpressure: third accept fills the ready threshold.
    pop_log.delete();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 3'b000, 32'h5000 + 32'(4*i), 32'(i + 1), 1'b0, acc);
      chk("bp_accept", acc, 1'b1);
    end
    chk("bp_ready_low", req_ready, 1'b0);
    step(1'b1, 3'b000, 32'h500C, 32'd4, 1'b0, acc);
    chk("bp_reject", acc, 1'b0);
    send(3'b000, 32'h500C, 32'd4, 1'b1);
    drain();
    chk("bp_count", pop_log.size(), 4);
    for (int i = 0; i < 4 && i < pop_log.size(); i++)
      chk("bp_order", pop_log[i], 32'h5000 + 32'(4*i));

    // Misaligned word.
    send(3'b000, 32'h0000_4001, 32'h1122_3344, 1'b0);
`ifdef STORE_MISALIGN_SPLIT_EN
    chk("split_first", {mem_valid, mem_addr, mem_be, mem_wdata},
        {1'b1, 32'h4000, 4'b1110, 32'h2233_4411});
    idle(1'b1);
    chk("split_second", {mem_valid, mem_addr, mem_be, mem_wdata},
        {1'b1, 32'h4004, 4'b0001, 32'h2233_4411});
    drain();
`else
    chk("mis_err_pulse", {misalign_err, busy}, {1'b1, 1'b0});
    idle(1'b1);
    chk("mis_err_end", {misalign_err, busy}, {1'b0, 1'b0});
`endif
    step(1'b1, 3'b010, 32'h0000_0011, 32'h0000_CAFE, 1'b0, acc);
    step(1'b1, 3'b010, 32'h0000_0023, 32'h0000_F00D, 1'b0, acc);
    drain();

    // Reset with three beats buffered.
    for (int i = 0; i < 3; i++) send(3'b000, 32'h6000 + 32'(4*i), 32'hA0 + 32'(i), 1'b0);
    chk("pre_rst_busy", busy, 1'b1);
    do_reset();
    chk("post_rst", {mem_valid, busy, req_ready}, {1'b0, 1'b0, 1'b1});

    // Random traffic, including address wrap at the top of memory.
    for (int n = 0; n < 400; n++) begin
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFC | {30'd0, a[1:0]};
      step($urandom_range(0, 3) != 0, funcs[$urandom_range(0, 4)], a, $urandom,
           $urandom_range(0, 2) != 0, acc);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
